// File: rtl/logic_unit_pipe_if.sv
// logic_unit_pipe_if: operand/result handshake bundle for logic_unit_pipe.
// Producer-side signals (operands, op, frame flags) and consumer-side
// signals (result, parity, out_ready) share one bundle. The out_count
// signal exists only when LOGIC_PIPE_FRAME_COUNT_EN is defined.
interface logic_unit_pipe_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             acc_en;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             out_parity;
`ifdef LOGIC_PIPE_FRAME_COUNT_EN
    logic [CNT_W-1:0] out_count;
`endif

    // Reject degenerate widths at elaboration time.
    if (WIDTH < 1 || CNT_W < 1) begin : g_param_err
        $error("logic_unit_pipe_if: WIDTH and CNT_W must be >= 1");
    end

    // Driver of operands and consumer of results.
    modport master (
        output in_valid, a, b, op, acc_en, in_last, out_ready,
        input  in_ready, out_valid, out, out_parity
`ifdef LOGIC_PIPE_FRAME_COUNT_EN
        , input out_count
`endif
    );

    // The logic unit itself.
    modport slave (
        input  in_valid, a, b, op, acc_en, in_last, out_ready,
        output in_ready, out_valid, out, out_parity
`ifdef LOGIC_PIPE_FRAME_COUNT_EN
        , output out_count
`endif
    );
endinterface

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: registered bitwise logic unit with valid/ready handshake,
// one-entry output register, registered parity and XOR-accumulate frames.
// Optional feature macro: LOGIC_PIPE_FRAME_COUNT_EN adds a saturating frame
// beat counter and the out_count result field.
module logic_unit_pipe #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    logic_unit_pipe_if.slave   bus
);
    // Reject degenerate widths at elaboration time.
    if (WIDTH < 1 || CNT_W < 1) begin : g_param_err
        $error("logic_unit_pipe: WIDTH and CNT_W must be >= 1");
    end

    logic [WIDTH-1:0] out_q, out_d;
    logic             out_parity_q, out_parity_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] acc_q, acc_d;

    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] res;
    logic             in_ready;
    logic             accept;
    logic             load;

    // The slot is free when empty or being drained this cycle.
    assign in_ready     = !out_valid_q || bus.out_ready;
    assign accept       = bus.in_valid && in_ready;
    // Direct beats and frame-closing beats load the output register.
    assign load         = accept && (!bus.acc_en || bus.in_last);

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.out        = out_q;
    assign bus.out_parity = out_parity_q;

    // Bitwise operation select.
    always_comb begin
        r = '0;
        unique case (bus.op)
            3'd0: r = bus.a & bus.b;
            3'd1: r = bus.a | bus.b;
            3'd2: r = bus.a ^ bus.b;
            3'd3: r = ~(bus.a & bus.b);
            3'd4: r = ~(bus.a | bus.b);
            3'd5: r = ~(bus.a ^ bus.b);
            3'd6: r = ~bus.a;
            3'd7: r = bus.a;
            default: r = '0;
        endcase
    end

    // Output register, parity and accumulator next state.
    always_comb begin
        out_d        = out_q;
        out_parity_d = out_parity_q;
        out_valid_d  = out_valid_q;
        acc_d        = acc_q;
        // Frame results fold in the accumulator; direct beats do not,
        // so a direct beat mid-frame leaves the frame intact.
        res          = bus.acc_en ? (acc_q ^ r) : r;

        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
        if (load) begin
            out_d        = res;
            out_parity_d = ^res;
            out_valid_d  = 1'b1;
        end
        if (accept && bus.acc_en) begin
            acc_d = bus.in_last ? '0 : (acc_q ^ r);
        end
    end

    // State registers; reset discards any partial frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q        <= '0;
            out_parity_q <= 1'b0;
            out_valid_q  <= 1'b0;
            acc_q        <= '0;
        end else begin
            out_q        <= out_d;
            out_parity_q <= out_parity_d;
            out_valid_q  <= out_valid_d;
            acc_q        <= acc_d;
        end
    end

`ifdef LOGIC_PIPE_FRAME_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic [CNT_W-1:0] cnt_inc;

    assign bus.out_count = out_count_q;

    // Frame beat counter and emitted count; the counter saturates.
    always_comb begin
        cnt_d       = cnt_q;
        out_count_d = out_count_q;
        cnt_inc     = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
        if (accept && bus.acc_en) begin
            if (bus.in_last) begin
                out_count_d = cnt_inc;
                cnt_d       = '0;
            end else begin
                cnt_d       = cnt_inc;
            end
        end else if (load) begin
            out_count_d = CNT_W'(1);
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            out_count_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            out_count_q <= out_count_d;
        end
    end
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: directed plan checks plus randomized traffic against a
// frame-level reference model (per-bit truth tables, a queue of frame beats).
module tb_logic_unit_pipe;
    logic clk = 1'b0;
    logic reset;
    logic reset_w;
    always #5 clk = ~clk;

    logic_unit_pipe_if #(.WIDTH(16), .CNT_W(8)) bus ();
    logic_unit_pipe_if #(.WIDTH(5),  .CNT_W(2)) busw ();

    logic_unit_pipe #(.WIDTH(16), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    logic_unit_pipe #(.WIDTH(5), .CNT_W(2)) dut_w (
        .clk(clk), .reset(reset_w), .bus(busw)
    );

    int n_vec = 0;
    int n_err = 0;

    // Truth tables indexed by {a_bit, b_bit}.
    logic [3:0] tt [8] = '{4'b1000, 4'b1110, 4'b0110, 4'b0111,
                           4'b0001, 4'b1001, 4'b0011, 4'b1100};

    // Reference model state.
    logic        m_valid = 1'b0;
    logic [15:0] m_out   = '0;
    int          m_count = 0;
    logic [15:0] beats[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_op(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y);
        logic [15:0] z;
        logic [3:0]  t;
        t = tt[o];
        for (int i = 0; i < 16; i++) z[i] = t[{x[i], y[i]}];
        return z;
    endfunction

    // One clock: drive, check in_ready, clock edge, update model, check outputs.
    task automatic cyc(input logic v, input logic [15:0] ai, input logic [15:0] bi,
                       input logic [2:0] oi, input logic ae, input logic last,
                       input logic ordy, input logic rst);
        logic        rdy;
        logic [15:0] r;
        logic [15:0] x;
        bus.in_valid  = v;
        bus.a         = ai;
        bus.b         = bi;
        bus.op        = oi;
        bus.acc_en    = ae;
        bus.in_last   = last;
        bus.out_ready = ordy;
        reset         = rst;
        rdy = !m_valid || ordy;
        #1;
        if (!rst) chk("in_ready", {31'd0, bus.in_ready}, {31'd0, rdy});
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0;
            m_out   = '0;
            m_count = 0;
            beats.delete();
        end else begin
            if (m_valid && ordy) m_valid = 1'b0;
            if (v && rdy) begin
                r = ref_op(oi, ai, bi);
                if (!ae) begin
                    m_out   = r;
                    m_valid = 1'b1;
                    m_count = 1;
                end else begin
                    beats.push_back(r);
                    if (last) begin
                        x = '0;
                        foreach (beats[k]) x ^= beats[k];
                        m_out   = x;
                        m_valid = 1'b1;
                        m_count = (beats.size() > 255) ? 255 : beats.size();
                        beats.delete();
                    end
                end
            end
        end
        #1;
        chk("out_valid",  {31'd0, bus.out_valid},  {31'd0, m_valid});
        chk("out",        {16'd0, bus.out},        {16'd0, m_out});
        chk("out_parity", {31'd0, bus.out_parity}, {31'd0, ^m_out});
`ifdef LOGIC_PIPE_FRAME_COUNT_EN
        chk("out_count",  {24'd0, bus.out_count},  m_count);
`endif
    endtask

    initial begin
        reset_w = 1'b1;
        busw.in_valid = 0; busw.a = '0; busw.b = '0; busw.op = 3'd7;
        busw.acc_en = 0; busw.in_last = 0; busw.out_ready = 1'b1;

        // Reset and reset-state check.
        cyc(0, 0, 0, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 0, 0, 1, 1);
        chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out",   {16'd0, bus.out},       32'd0);

        // XOR direct beat, then drains.
        cyc(1, 16'hF0F0, 16'h0FF0, 3'd2, 0, 0, 1, 0);
        chk("xor_out", {16'd0, bus.out}, 32'h0000FF00);
        chk("xor_par", {31'd0, bus.out_parity}, 32'd0);
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        chk("xor_drain", {31'd0, bus.out_valid}, 32'd0);

        // NAND then NOR back to back, no bubble.
        cyc(1, 16'hFFFF, 16'hFFFF, 3'd3, 0, 0, 1, 0);
        chk("nand_out", {16'd0, bus.out}, 32'h0);
        cyc(1, 16'h0000, 16'h0000, 3'd4, 0, 0, 1, 0);
        chk("nor_out", {16'd0, bus.out}, 32'hFFFF);
        chk("nor_valid", {31'd0, bus.out_valid}, 32'd1);

        // Backpressure: result held for three stalled cycles.
        cyc(1, 16'h00FF, 16'h0F0F, 3'd0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 16'h1234, 16'h00FF, 3'd1, 0, 0, 0, 0);
            chk("bp_hold", {16'd0, bus.out}, 32'h000F);
        end
        cyc(1, 16'h1234, 16'h00FF, 3'd1, 0, 0, 1, 0);
        chk("bp_next", {16'd0, bus.out}, 32'h12FF);
        cyc(0, 0, 0, 0, 0, 0, 1, 0);

        // Three-beat accumulate frame of pass-a.
        cyc(1, 16'h0001, 16'h0, 3'd7, 1, 0, 1, 0);
        chk("acc_noload", {31'd0, bus.out_valid}, 32'd0);
        cyc(1, 16'h0002, 16'h0, 3'd7, 1, 0, 1, 0);
        cyc(1, 16'h0004, 16'h0, 3'd7, 1, 1, 1, 0);
        chk("acc_out", {16'd0, bus.out}, 32'h7);
        chk("acc_par", {31'd0, bus.out_parity}, 32'd1);
`ifdef LOGIC_PIPE_FRAME_COUNT_EN
        chk("acc_cnt", {24'd0, bus.out_count}, 32'd3);
`endif
        cyc(0, 0, 0, 0, 0, 0, 1, 0);

        // Reset mid-frame discards the partial accumulation.
        cyc(1, 16'h00F0, 16'h0, 3'd7, 1, 0, 1, 0);
        cyc(1, 16'h000F, 16'h0, 3'd7, 1, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 1);
        cyc(1, 16'h1000, 16'h0, 3'd7, 1, 1, 1, 0);
        chk("rst_frame", {16'd0, bus.out}, 32'h1000);
`ifdef LOGIC_PIPE_FRAME_COUNT_EN
        chk("rst_cnt", {24'd0, bus.out_count}, 32'd1);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(0, 99) < 75,
                16'($urandom), 16'($urandom), 3'($urandom),
                $urandom_range(0, 99) < 45,
                $urandom_range(0, 2) == 0,
                $urandom_range(0, 99) < 70,
                $urandom_range(0, 149) == 0);
        end

        // Narrow instance: five-beat frame saturates a 2-bit counter.
        reset = 1'b0;
        @(posedge clk); #1;
        reset_w = 1'b0;
        for (int i = 0; i < 5; i++) begin
            busw.in_valid = 1'b1;
            busw.a        = 5'h01;
            busw.op       = 3'd7;
            busw.acc_en   = 1'b1;
            busw.in_last  = (i == 4);
            @(posedge clk); #1;
        end
        busw.in_valid = 1'b0;
        chk("w5_valid", {31'd0, busw.out_valid}, 32'd1);
        chk("w5_out",   {27'd0, busw.out},       32'h01);
`ifdef LOGIC_PIPE_FRAME_COUNT_EN
        chk("w5_cnt",   {30'd0, busw.out_count}, 32'd3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
